pwm_capture_channel: RTL
========================

// Module: pwm_capture_channel
// PURPOSE
// - Receive side of PWM: measures period and on-time of an external PWM input in clk cycles.
// - Each instance is one capture unit on the shared IO_bus register map, beside the PWM generator channels.
// - Register access goes through a bus_FSM instance, as for every other bus subsystem.
// PARAMETERS
// - CAP_UNIT        0      unit index; register base = `PWM_CAP_PERIOD + CAP_UNIT*`NOS_PWM_CAP_REGISTERS
// - TIMEOUT_CYCLES  1000000  idle limit in clk cycles (used only with PWM_CAP_TIMEOUT_EN)
// PORTS
// - clk         input   1       system clock; all logic on posedge
// - reset       input   1       synchronous, active-high
// - bus         IO_bus  -       handshake_1/handshake_2/RW/reg_address/data_out in; data_in out (tri-state)
// - pwm_in      input   1       asynchronous external PWM signal
// - cap_valid   output  1       copy of STATUS[1]: new measurement available
// BEHAVIOUR
// - Registers, offsets from the unit base: PERIOD +0 (RO), ON_TIME +1 (RO), CONFIG +2 (RW), STATUS +3 (RO).
//   - CONFIG[0] = enable. Other CONFIG bits read back as written and have no function.
//   - STATUS = {28'b0, timeout, overflow, valid, enable}.
// - Reset: PERIOD, ON_TIME, CONFIG, STATUS, counters = 0. FSM = IDLE. cap_valid = 0. bus.data_in = 'z.
// - Input path: pwm_in -> 2-flop synchroniser -> edge register.
//   - A rise or fall is detected 3 clks after the pin edge.
//   - Pulses shorter than 1 clk may be lost.
// - Counters: period_cnt and on_cnt, 32 bits, unsigned.
//   - Both are loaded with 1 on the cycle after a detected rise and increment every clk after that.
//   - At 32'hFFFF_FFFF they hold and set STATUS overflow (sticky).
// - FSM:
//   - IDLE: entered whenever enable = 0; counters cleared. Leaves to WAIT_RISE when enable = 1.
//   - WAIT_RISE: first rise -> HIGH (counters start). Nothing is captured on this first rise.
//   - HIGH: detected fall -> ON_TIME <= on_cnt; go to LOW.
//   - LOW: detected rise -> PERIOD <= period_cnt; valid <= 1; counters restart; go to HIGH.
// - Measured results: PERIOD = rise-to-rise clk count; ON_TIME = rise-to-fall clk count.
//   - The first valid result appears after the second detected rise.
// - Bus writes: accepted only to CONFIG, on the read_word_from_BUS strobe. Writes to RO registers are ignored.
// - Bus reads: the addressed register is latched on the write_data_word_to_BUS strobe.
//   - write_status_word_to_BUS returns STATUS.
//   - bus.data_in is driven only while reg_address is inside this unit's 4 registers; otherwise 'z.
// - Clearing flags: a bus read of PERIOD clears valid, overflow and timeout on the following clk.
// - Simultaneous events:
//   - Capture and valid-clear in the same clk: capture wins, so valid = 1. The bus returns the pre-capture PERIOD.
//   - A CONFIG write that clears enable, in any state: FSM -> IDLE next clk. Counters are cleared. PERIOD, ON_TIME and flags are retained.
// - Reset asserted mid-measurement: the measurement is aborted and all state returns to reset values next clk.
// CONFIGURATION
// - PWM_CAP_TIMEOUT_EN defined:
//   - In HIGH or LOW, period_cnt == TIMEOUT_CYCLES sets timeout (sticky).
//   - The same event sets PERIOD = ON_TIME = 0 and valid = 1, and the FSM goes to WAIT_RISE.
//   - This reports a stuck-high or stuck-low input.
// - PWM_CAP_TIMEOUT_EN undefined:
//   - No timeout logic. STATUS[3] reads 0.
//   - A stuck input leaves the counters saturating and sets overflow.
// TESTING
// - Reset, then read all 4 registers -> all 0; bus.data_in = 'z for an address outside the unit.
// - Enable, then drive pwm_in with period 100, high 30 clks -> after the 2nd rise PERIOD = 100, ON_TIME = 30, valid = 1.
// - Change pwm_in to period 50, high 49 -> next capture PERIOD = 50, ON_TIME = 49. Read PERIOD -> valid = 0 next clk.
// - Capture and PERIOD read in the same clk -> bus gets the old value, valid stays 1, PERIOD updated.
// - Clear enable while in HIGH -> FSM IDLE, old results kept. Re-enable -> the first rise captures nothing.
// - TIMEOUT_EN, TIMEOUT_CYCLES = 200, pwm_in held high -> PERIOD = 0, ON_TIME = 0, STATUS = 4'b1011.

Source files
------------

// File: rtl/pwm_capture_channel_if.sv
// rtl/pwm_capture_channel_if.sv - IO_bus register interface shared by the capture units (address map macros PWM_CAP_PERIOD, NOS_PWM_CAP_REGISTERS)
`ifndef PWM_CAP_PERIOD
`define PWM_CAP_PERIOD 64
`endif
`ifndef NOS_PWM_CAP_REGISTERS
`define NOS_PWM_CAP_REGISTERS 4
`endif

interface IO_bus;
  logic        handshake_1;
  logic        handshake_2;
  logic        RW;
  logic [7:0]  reg_address;
  logic [31:0] data_out;
  wire  [31:0] data_in;
  logic        data_in_en;

  modport master (
    output handshake_1, handshake_2, RW, reg_address, data_out,
    input  data_in, data_in_en
  );

  modport slave (
    input  handshake_1, handshake_2, RW, reg_address, data_out,
    output data_in, data_in_en
  );
endinterface

// File: rtl/pwm_capture_channel.sv
// rtl/pwm_capture_channel.sv - PWM capture unit measuring period and on-time; optional stuck-input timeout under PWM_CAP_TIMEOUT_EN
`ifndef PWM_CAP_PERIOD
`define PWM_CAP_PERIOD 64
`endif
`ifndef NOS_PWM_CAP_REGISTERS
`define NOS_PWM_CAP_REGISTERS 4
`endif

module pwm_capture_channel #(
  parameter int CAP_UNIT       = 0,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic  clk,
  input  logic  reset,
  IO_bus.slave  bus,
  input  logic  pwm_in,
  output logic  cap_valid
);

  localparam int          BASE          = `PWM_CAP_PERIOD + CAP_UNIT * `NOS_PWM_CAP_REGISTERS;
  localparam logic [7:0]  BASE_ADDR     = BASE[7:0];
  localparam logic [31:0] TIMEOUT_LIMIT = TIMEOUT_CYCLES[31:0];

  typedef enum logic [1:0] {IDLE, WAIT_RISE, HIGH, LOW} state_t;

  state_t      state;
  logic [2:0]  sync;          // [0],[1] synchroniser, [2] edge register
  logic        rise, fall;
  logic        hs1_q, hs2_q;
  logic [7:0]  addr_off;
  logic        addr_hit;
  logic        read_word_from_bus, write_data_word_to_bus, write_status_word_to_bus;
  logic        period_read;
  logic [31:0] period_reg, on_time_reg, config_reg, rd_latch, reg_mux, status_word;
  logic [31:0] period_cnt, on_cnt;
  logic        valid_flag, overflow_flag, timeout_flag;

  assign rise = sync[1] & ~sync[2];
  assign fall = ~sync[1] & sync[2];

  // Offsets below the base wrap to large values, so one upper-bits test covers both bounds
  assign addr_off = bus.reg_address - BASE_ADDR;
  assign addr_hit = (addr_off[7:2] == 6'd0);

  assign read_word_from_bus       = bus.handshake_1 & ~hs1_q & bus.RW;
  assign write_data_word_to_bus   = bus.handshake_1 & ~hs1_q & ~bus.RW;
  assign write_status_word_to_bus = bus.handshake_2 & ~hs2_q;
  assign period_read              = write_data_word_to_bus & addr_hit & (addr_off[1:0] == 2'd0);

  assign status_word = {28'b0, timeout_flag, overflow_flag, valid_flag, config_reg[0]};

  // Register select for bus reads
  always_comb begin
    reg_mux = status_word;
    case (addr_off[1:0])
      2'd0:    reg_mux = period_reg;
      2'd1:    reg_mux = on_time_reg;
      2'd2:    reg_mux = config_reg;
      default: reg_mux = status_word;
    endcase
  end

  assign bus.data_in_en = addr_hit;
  assign bus.data_in    = addr_hit ? rd_latch : 'z;
  assign cap_valid      = valid_flag;

`ifndef PWM_CAP_TIMEOUT_EN
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_LIMIT;
  assign timeout_flag   = 1'b0;
`endif

  // Input synchroniser/edge register and handshake history for strobe detection
  always_ff @(posedge clk) begin
    if (reset) begin
      sync  <= 3'b000;
      hs1_q <= 1'b0;
      hs2_q <= 1'b0;
    end else begin
      sync  <= {sync[1:0], pwm_in};
      hs1_q <= bus.handshake_1;
      hs2_q <= bus.handshake_2;
    end
  end

  // Bus side: CONFIG writes and read-data latch (latched value is pre-capture on a simultaneous edge)
  always_ff @(posedge clk) begin
    if (reset) begin
      config_reg <= 32'd0;
      rd_latch   <= 32'd0;
    end else begin
      if (read_word_from_bus && addr_hit && addr_off[1:0] == 2'd2)
        config_reg <= bus.data_out;
      if (write_data_word_to_bus)
        rd_latch <= reg_mux;
      else if (write_status_word_to_bus)
        rd_latch <= status_word;
    end
  end

  // Measurement FSM; flag clear comes first so a capture on the same edge keeps valid set
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      period_cnt    <= 32'd0;
      on_cnt        <= 32'd0;
      period_reg    <= 32'd0;
      on_time_reg   <= 32'd0;
      valid_flag    <= 1'b0;
      overflow_flag <= 1'b0;
`ifdef PWM_CAP_TIMEOUT_EN
      timeout_flag  <= 1'b0;
`endif
    end else begin
      if (period_read) begin
        valid_flag    <= 1'b0;
        overflow_flag <= 1'b0;
`ifdef PWM_CAP_TIMEOUT_EN
        timeout_flag  <= 1'b0;
`endif
      end
      if (!config_reg[0]) begin
        state      <= IDLE;
        period_cnt <= 32'd0;
        on_cnt     <= 32'd0;
      end else begin
        case (state)
          IDLE: state <= WAIT_RISE;
          WAIT_RISE: begin
            if (rise) begin
              period_cnt <= 32'd1;
              on_cnt     <= 32'd1;
              state      <= HIGH;
            end
          end
          default: begin
            if (period_cnt == '1) overflow_flag <= 1'b1;
            else                  period_cnt    <= period_cnt + 32'd1;
            if (on_cnt == '1)     overflow_flag <= 1'b1;
            else                  on_cnt        <= on_cnt + 32'd1;
            if (state == HIGH && fall) begin
              on_time_reg <= on_cnt;
              state       <= LOW;
            end
            if (state == LOW && rise) begin
              period_reg <= period_cnt;
              valid_flag <= 1'b1;
              period_cnt <= 32'd1;
              on_cnt     <= 32'd1;
              state      <= HIGH;
            end
          end
        endcase
`ifdef PWM_CAP_TIMEOUT_EN
        if ((state == HIGH || state == LOW) && period_cnt == TIMEOUT_LIMIT) begin
          timeout_flag <= 1'b1;
          period_reg   <= 32'd0;
          on_time_reg  <= 32'd0;
          valid_flag   <= 1'b1;
          state        <= WAIT_RISE;
        end
`endif
      end
    end
  end

endmodule
